hazard_control_unit: RTL and testbench

Pipeline hazard sequencer for the 5-stage core; drives the PC, IF/ID and ID/EX pipeline registers.
- Detects load-use hazards between the instruction in Decode and a load in Execute; stalls PC and IF/ID and inserts a bubble into ID/EX.
- Flushes IF/ID on a taken branch or jump resolved in Decode.
- A small FSM with a down-counter stretches stalls and flushes to parameterised lengths.

---
 rtl/hazard_control_unit.sv | 135 +++++++++++++
 tb/tb_hazard_control_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Load-use stall / branch flush sequencer for the 5-stage pipeline.
// Optional macro HAZARD_PERF_CNT_EN adds saturating StallCount/FlushCount ports.
module hazard_control_unit #(
  parameter int unsigned LOAD_STALL_CYCLES   = 1,
  parameter int unsigned BRANCH_FLUSH_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  RSDecode,
  input  logic [4:0]  RTDecode,
  input  logic        UsesRTDecode,
  input  logic [1:0]  MemReadExecute,
  input  logic [4:0]  DestRegExecute,
  input  logic        BranchTakenDecode,
  input  logic        JumpDecode,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount,
`endif
  output logic [1:0]  HazardState
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LS_LOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] FL_LOAD = CNT_W'(BRANCH_FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load_use;
  logic             w_redirect;

  // Register $0 is hardwired zero and can never be a hazard source.
  assign w_load_use = (MemReadExecute != 2'd0) && (DestRegExecute != 5'd0) &&
                      ((DestRegExecute == RSDecode) ||
                       (UsesRTDecode && (DestRegExecute == RTDecode)));
  assign w_redirect = BranchTakenDecode | JumpDecode;

  assign HazardState = r_state;

  // Mealy output decode from state and inputs.
  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    if (Reset) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else begin
      case (r_state)
        ST_LOAD_STALL: begin
          PCWrite   = 1'b0;
          IFIDWrite = 1'b0;
          IDEXFlush = 1'b1;
        end
        ST_FLUSH: begin
          IFIDFlush = 1'b1;
        end
        default: begin
          if (w_load_use) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
          end else if (w_redirect) begin
            IFIDFlush = 1'b1;
          end
        end
      endcase
    end
  end

  // State and down-counter; a count of 1 (or a stray 0) ends the stretch.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_LOAD_STALL, ST_FLUSH: begin
          if (r_cnt > CNT_W'(1)) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_cnt   <= '0;
          if (w_load_use) begin
            if (LOAD_STALL_CYCLES > 1) begin
              r_state <= ST_LOAD_STALL;
              r_cnt   <= LS_LOAD;
            end
          end else if (w_redirect) begin
            if (BRANCH_FLUSH_CYCLES > 1) begin
              r_state <= ST_FLUSH;
              r_cnt   <= FL_LOAD;
            end
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (!PCWrite && (StallCount != 32'hFFFF_FFFF)) begin
        StallCount <= StallCount + 32'd1;
      end
      if (IFIDFlush && (FlushCount != 32'hFFFF_FFFF)) begin
        FlushCount <= FlushCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: instance a uses 1/1 lengths, b uses 3/2.
module tb_hazard_control_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [4:0] RSDecode, RTDecode, DestRegExecute;
  logic       UsesRTDecode, BranchTakenDecode, JumpDecode;
  logic [1:0] MemReadExecute;

  logic       a_pcw, a_ifw, a_iff, a_idf;
  logic       b_pcw, b_ifw, b_iff, b_idf;
  logic [1:0] a_state, b_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  hazard_control_unit #(.LOAD_STALL_CYCLES(1), .BRANCH_FLUSH_CYCLES(1)) u_dut_a (
    .Clk(Clk), .Reset(Reset), .RSDecode(RSDecode), .RTDecode(RTDecode),
    .UsesRTDecode(UsesRTDecode), .MemReadExecute(MemReadExecute),
    .DestRegExecute(DestRegExecute), .BranchTakenDecode(BranchTakenDecode),
    .JumpDecode(JumpDecode), .PCWrite(a_pcw), .IFIDWrite(a_ifw),
    .IFIDFlush(a_iff), .IDEXFlush(a_idf),
`ifdef HAZARD_PERF_CNT_EN
    .StallCount(a_stall_cnt), .FlushCount(a_flush_cnt),
`endif
    .HazardState(a_state)
  );

  hazard_control_unit #(.LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_CYCLES(2)) u_dut_b (
    .Clk(Clk), .Reset(Reset), .RSDecode(RSDecode), .RTDecode(RTDecode),
    .UsesRTDecode(UsesRTDecode), .MemReadExecute(MemReadExecute),
    .DestRegExecute(DestRegExecute), .BranchTakenDecode(BranchTakenDecode),
    .JumpDecode(JumpDecode), .PCWrite(b_pcw), .IFIDWrite(b_ifw),
    .IFIDFlush(b_iff), .IDEXFlush(b_idf),
`ifdef HAZARD_PERF_CNT_EN
    .StallCount(b_stall_cnt), .FlushCount(b_flush_cnt),
`endif
    .HazardState(b_state)
  );

  // Output vectors ordered {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush}.
  logic [3:0] a_outs, b_outs;
  assign a_outs = {a_pcw, a_ifw, a_iff, a_idf};
  assign b_outs = {b_pcw, b_ifw, b_iff, b_idf};

  localparam logic [3:0] O_RUN   = 4'b1100;
  localparam logic [3:0] O_STALL = 4'b0001;
  localparam logic [3:0] O_FLUSH = 4'b1110;
  localparam logic [3:0] O_RST   = 4'b0011;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    RSDecode = 5'd0; RTDecode = 5'd0; DestRegExecute = 5'd0;
    UsesRTDecode = 1'b0; MemReadExecute = 2'd0;
    BranchTakenDecode = 1'b0; JumpDecode = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    clear_inputs();
    #1;
    // Reset held for two cycles.
    chk("rst_outs_a", 32'(a_outs), 32'(O_RST));
    chk("rst_outs_b", 32'(b_outs), 32'(O_RST));
    tick();
    chk("rst_state_a", 32'(a_state), 32'd0);
    chk("rst_outs2_b", 32'(b_outs), 32'(O_RST));
    tick();
    Reset = 1'b0;
    #1;
    chk("idle_outs_a", 32'(a_outs), 32'(O_RUN));
    chk("idle_outs_b", 32'(b_outs), 32'(O_RUN));
    chk("idle_state_b", 32'(b_state), 32'd0);

    // Single-cycle load-use via rs.
    MemReadExecute = 2'b11; DestRegExecute = 5'd8; RSDecode = 5'd8;
    #1;
    chk("lu1_outs_a", 32'(a_outs), 32'(O_STALL));
    tick();
    chk("lu1_state_a", 32'(a_state), 32'd0);
    clear_inputs();
    #1;
    chk("lu1_after_a", 32'(a_outs), 32'(O_RUN));
    do_reset();
    MemReadExecute = 2'b11; DestRegExecute = 5'd0; RSDecode = 5'd0;
    #1;
    chk("r0_nostall_a", 32'(a_outs), 32'(O_RUN));
    chk("r0_nostall_b", 32'(b_outs), 32'(O_RUN));

    // Three-cycle load-use via rt on instance b.
    do_reset();
    MemReadExecute = 2'b01; DestRegExecute = 5'd9; RTDecode = 5'd9;
    RSDecode = 5'd3; UsesRTDecode = 1'b1;
    #1;
    chk("lu3_c1_outs_b", 32'(b_outs), 32'(O_STALL));
    chk("lu3_c1_state_b", 32'(b_state), 32'd0);
    tick();
    chk("lu3_c2_outs_b", 32'(b_outs), 32'(O_STALL));
    chk("lu3_c2_state_b", 32'(b_state), 32'd1);
    tick();
    chk("lu3_c3_outs_b", 32'(b_outs), 32'(O_STALL));
    chk("lu3_c3_state_b", 32'(b_state), 32'd1);
    tick();
    chk("lu3_end_state_b", 32'(b_state), 32'd0);
    clear_inputs();
    #1;
    chk("lu3_end_outs_b", 32'(b_outs), 32'(O_RUN));
    MemReadExecute = 2'b01; DestRegExecute = 5'd9; RTDecode = 5'd9;
    RSDecode = 5'd3; UsesRTDecode = 1'b0;
    #1;
    chk("rt_unused_b", 32'(b_outs), 32'(O_RUN));

    // Branch together with load-use: stall first, flush afterwards.
    do_reset();
    MemReadExecute = 2'b10; DestRegExecute = 5'd5; RSDecode = 5'd5;
    BranchTakenDecode = 1'b1;
    #1;
    chk("br_lu_outs_a", 32'(a_outs), 32'(O_STALL));
    tick();
    MemReadExecute = 2'b00;
    #1;
    chk("br_after_outs_a", 32'(a_outs), 32'(O_FLUSH));
    tick();
    clear_inputs();
    #1;
    chk("br_done_outs_a", 32'(a_outs), 32'(O_RUN));

    // Two-cycle jump flush aborted by reset in its second cycle.
    do_reset();
    JumpDecode = 1'b1;
    #1;
    chk("jmp_c1_outs_b", 32'(b_outs), 32'(O_FLUSH));
    tick();
    JumpDecode = 1'b0;
    #1;
    chk("jmp_c2_outs_b", 32'(b_outs), 32'(O_FLUSH));
    chk("jmp_c2_state_b", 32'(b_state), 32'd2);
    Reset = 1'b1;
    #1;
    chk("jmp_rst_outs_b", 32'(b_outs), 32'(O_RST));
    tick();
    chk("jmp_rst_state_b", 32'(b_state), 32'd0);
    Reset = 1'b0;
    #1;
    chk("jmp_rel_outs_b", 32'(b_outs), 32'(O_RUN));
    tick();
    chk("jmp_rel2_outs_b", 32'(b_outs), 32'(O_RUN));
    chk("jmp_rel2_state_b", 32'(b_state), 32'd0);

`ifdef HAZARD_PERF_CNT_EN
    // Two 3-cycle stalls and one 2-cycle flush on instance b.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      MemReadExecute = 2'b11; DestRegExecute = 5'd7; RSDecode = 5'd7;
      tick(); tick(); tick();
      clear_inputs();
      tick();
    end
    JumpDecode = 1'b1;
    tick();
    JumpDecode = 1'b0;
    tick();
    chk("perf_stall_b", b_stall_cnt, 32'd6);
    chk("perf_flush_b", b_flush_cnt, 32'd2);
    Reset = 1'b1;
    tick();
    chk("perf_rst_stall_b", b_stall_cnt, 32'd0);
    chk("perf_rst_flush_b", b_flush_cnt, 32'd0);
    Reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
